// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Stall/flush sequencer for the 5-stage RV32I pipeline. It merges three inputs
// into per-register load enables and flush strobes:
//   - the load-use hazard from ID,
//   - taken-branch redirects resolved in EX,
//   - the data-memory request/ready handshake from MEM.
// Multi-cycle events (load-use bubbles, memory waits) are tracked by a small
// FSM. Two saturating performance counters are kept, and the pipeline is
// frozen permanently if data memory does not answer within MEM_TIMEOUT cycles.
//
// Parameters
//   LOAD_USE_CYCLES  bubbles inserted per load-use hazard (1..15)
//   MEM_TIMEOUT      max consecutive memory-wait cycles before halting (1..255)
//   CNT_WIDTH        width of each performance counter
//
// Ports
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   ID_stale         in   load-use hazard detected in ID
//   EX_branch_taken  in   branch/jump resolved taken in EX
//   MEM_dmem_req     in   MEM stage issues a data-memory access
//   MEM_dmem_ready   in   data memory completes the access this cycle
//   pc_write         out  PC load enable
//   IF_ID_write      out  IF/ID load enable
//   IF_ID_flush      out  IF/ID cleared to NOP
//   ID_EX_write      out  ID/EX load enable
//   ID_EX_flush      out  ID/EX cleared to NOP (bubble)
//   EX_MEM_write     out  EX/MEM and MEM/WB load enable
//   halted           out  sticky memory-timeout indication
//   stall_count      out  saturating count of cycles with pc_write=0
//   flush_count      out  saturating count of taken-branch flushes
//
// State table
//   state        | meaning
//   S_RUN        | normal flow; memory wait > branch > load-use priority
//   S_LOAD_STALL | extra load-use bubbles still pending (r_bub_cnt left)
//   S_MEM_WAIT   | data memory busy; whole pipeline frozen
//   S_HALT       | memory timeout; frozen until reset
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ID_stale,
  input  logic                 EX_branch_taken,
  input  logic                 MEM_dmem_req,
  input  logic                 MEM_dmem_ready,
  output logic                 pc_write,
  output logic                 IF_ID_write,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_write,
  output logic                 ID_EX_flush,
  output logic                 EX_MEM_write,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_LOAD_STALL = 2'd1;
  localparam logic [1:0] S_MEM_WAIT   = 2'd2;
  localparam logic [1:0] S_HALT       = 2'd3;

  localparam logic [3:0]           BUB_INIT   = 4'(LOAD_USE_CYCLES - 1);
  localparam logic [7:0]           WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  logic [1:0]           r_state;
  logic [3:0]           r_bub_cnt;
  logic [7:0]           r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic [1:0] w_next_state;
  logic [3:0] w_next_bub;
  logic [7:0] w_next_wait;
  logic [7:0] w_wait_inc;
  logic       w_mem_stall;
  logic       w_flush_event;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_if_id_flush;
  logic       w_id_ex_write;
  logic       w_id_ex_flush;
  logic       w_ex_mem_write;

  assign w_mem_stall = MEM_dmem_req & ~MEM_dmem_ready;
  assign w_wait_inc  = r_wait_cnt + 8'd1;

  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_write  = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_write = 1'b1;
    w_flush_event  = 1'b0;
    w_next_state   = r_state;
    w_next_bub     = r_bub_cnt;
    w_next_wait    = r_wait_cnt;

    case (r_state)
      // LOAD_STALL shares RUN's priority chain so that a branch or memory
      // wait arriving mid-bubble aborts the remaining bubbles.
      S_RUN, S_LOAD_STALL: begin
        if (w_mem_stall) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_write  = 1'b0;
          w_ex_mem_write = 1'b0;
          w_next_wait    = 8'd1;
          w_next_bub     = 4'd0;
          // The first waiting cycle already counts toward the timeout.
          w_next_state   = (WAIT_LIMIT == 8'd1) ? S_HALT : S_MEM_WAIT;
        end else if (EX_branch_taken) begin
          // The stale-load consumer sits in ID/IF and is flushed anyway.
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_flush_event = 1'b1;
          w_next_bub    = 4'd0;
          w_next_state  = S_RUN;
        end else if (r_state == S_LOAD_STALL) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
          if (r_bub_cnt <= 4'd1) begin
            w_next_bub   = 4'd0;
            w_next_state = S_RUN;
          end else begin
            w_next_bub = r_bub_cnt - 4'd1;
          end
        end else if (ID_stale) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
          if (BUB_INIT != 4'd0) begin
            w_next_bub   = BUB_INIT;
            w_next_state = S_LOAD_STALL;
          end
        end
      end

      S_MEM_WAIT: begin
        if (MEM_dmem_ready) begin
          w_next_wait  = 8'd0;
          w_next_state = S_RUN;
        end else begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_write  = 1'b0;
          w_ex_mem_write = 1'b0;
          w_next_wait    = w_wait_inc;
          if (w_wait_inc == WAIT_LIMIT) begin
            w_next_state = S_HALT;
          end
        end
      end

      S_HALT: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_ex_mem_write = 1'b0;
      end

      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_bub_cnt  <= 4'd0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_bub_cnt  <= w_next_bub;
      r_wait_cnt <= w_next_wait;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!w_pc_write && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (w_flush_event && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  // While reset is held the pipeline free-runs with no flushes, regardless
  // of what the hazard inputs are doing.
  assign pc_write     = ~rst_n | w_pc_write;
  assign IF_ID_write  = ~rst_n | w_if_id_write;
  assign ID_EX_write  = ~rst_n | w_id_ex_write;
  assign EX_MEM_write = ~rst_n | w_ex_mem_write;
  assign IF_ID_flush  =  rst_n & w_if_id_flush;
  assign ID_EX_flush  =  rst_n & w_id_ex_flush;
  assign halted       = (r_state == S_HALT);
  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Two instances share stimulus:
//   dut_a: LOAD_USE_CYCLES=1, MEM_TIMEOUT=8,   CNT_WIDTH=16
//   dut_b: LOAD_USE_CYCLES=3, MEM_TIMEOUT=255, CNT_WIDTH=4
module tb_pipeline_stall_controller;

  logic clk;
  logic rst_n;
  logic ID_stale;
  logic EX_branch_taken;
  logic MEM_dmem_req;
  logic MEM_dmem_ready;

  logic        a_pc_write, a_IF_ID_write, a_IF_ID_flush, a_ID_EX_write, a_ID_EX_flush;
  logic        a_EX_MEM_write, a_halted;
  logic [15:0] a_stall_count, a_flush_count;
  logic        b_pc_write, b_IF_ID_write, b_IF_ID_flush, b_ID_EX_write, b_ID_EX_flush;
  logic        b_EX_MEM_write, b_halted;
  logic [3:0]  b_stall_count, b_flush_count;

  int n_checks;
  int n_errors;

  pipeline_stall_controller #(
    .LOAD_USE_CYCLES(1), .MEM_TIMEOUT(8), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ID_stale(ID_stale), .EX_branch_taken(EX_branch_taken),
    .MEM_dmem_req(MEM_dmem_req), .MEM_dmem_ready(MEM_dmem_ready),
    .pc_write(a_pc_write), .IF_ID_write(a_IF_ID_write), .IF_ID_flush(a_IF_ID_flush),
    .ID_EX_write(a_ID_EX_write), .ID_EX_flush(a_ID_EX_flush), .EX_MEM_write(a_EX_MEM_write),
    .halted(a_halted), .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  pipeline_stall_controller #(
    .LOAD_USE_CYCLES(3), .MEM_TIMEOUT(255), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ID_stale(ID_stale), .EX_branch_taken(EX_branch_taken),
    .MEM_dmem_req(MEM_dmem_req), .MEM_dmem_ready(MEM_dmem_ready),
    .pc_write(b_pc_write), .IF_ID_write(b_IF_ID_write), .IF_ID_flush(b_IF_ID_flush),
    .ID_EX_write(b_ID_EX_write), .ID_EX_flush(b_ID_EX_flush), .EX_MEM_write(b_EX_MEM_write),
    .halted(b_halted), .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_stale        = 1'b0;
    EX_branch_taken = 1'b0;
    MEM_dmem_req    = 1'b0;
    MEM_dmem_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    ID_stale        = 1'b1;
    EX_branch_taken = 1'b1;
    MEM_dmem_req    = 1'b1;
    MEM_dmem_ready  = 1'b0;
    step();
    step();
    n_checks++;
    if ({a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write} !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_writes: got %b expected 1111",
               {a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write});
    end
    n_checks++;
    if ({a_IF_ID_flush, a_ID_EX_flush, b_IF_ID_flush, b_ID_EX_flush} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flush: got %b expected 0000",
               {a_IF_ID_flush, a_ID_EX_flush, b_IF_ID_flush, b_ID_EX_flush});
    end
    n_checks++;
    if ({a_halted, a_stall_count, a_flush_count} !== 33'd0) begin
      n_errors++;
      $display("FAIL reset_state: halted=%b stall=%0d flush=%0d expected 0/0/0",
               a_halted, a_stall_count, a_flush_count);
    end
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({a_pc_write, a_IF_ID_flush, a_ID_EX_flush} !== 3'b100) begin
      n_errors++;
      $display("FAIL run_default: pc/ifflush/exflush=%b expected 100",
               {a_pc_write, a_IF_ID_flush, a_ID_EX_flush});
    end
  endtask

  task automatic test_load_use_single();
    do_reset();
    ID_stale = 1'b1;
    #1;
    n_checks++;
    if ({a_pc_write, a_IF_ID_write, a_ID_EX_flush, a_ID_EX_write, a_EX_MEM_write} !== 5'b00111) begin
      n_errors++;
      $display("FAIL lu1_bubble: pc/ifw/exflush/exw/memw=%b expected 00111",
               {a_pc_write, a_IF_ID_write, a_ID_EX_flush, a_ID_EX_write, a_EX_MEM_write});
    end
    step();
    ID_stale = 1'b0;
    #1;
    n_checks++;
    if ({a_pc_write, a_ID_EX_flush} !== 2'b10 || a_stall_count !== 16'd1) begin
      n_errors++;
      $display("FAIL lu1_after: pc/exflush=%b stall=%0d expected 10 stall=1",
               {a_pc_write, a_ID_EX_flush}, a_stall_count);
    end
  endtask

  task automatic test_load_use_multi();
    do_reset();
    ID_stale = 1'b1;
    #1;
    n_checks++;
    if ({b_pc_write, b_IF_ID_write, b_ID_EX_flush} !== 3'b001) begin
      n_errors++;
      $display("FAIL lu3_bubble0: pc/ifw/exflush=%b expected 001",
               {b_pc_write, b_IF_ID_write, b_ID_EX_flush});
    end
    step();
    ID_stale = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      n_checks++;
      if ({b_pc_write, b_IF_ID_write, b_ID_EX_flush} !== 3'b001) begin
        n_errors++;
        $display("FAIL lu3_bubble%0d: pc/ifw/exflush=%b expected 001",
                 i, {b_pc_write, b_IF_ID_write, b_ID_EX_flush});
      end
      step();
    end
    #1;
    n_checks++;
    if ({b_pc_write, b_ID_EX_flush} !== 2'b10 || b_stall_count !== 4'd3) begin
      n_errors++;
      $display("FAIL lu3_done: pc/exflush=%b stall=%0d expected 10 stall=3",
               {b_pc_write, b_ID_EX_flush}, b_stall_count);
    end
    n_checks++;
    if (a_stall_count !== 16'd1) begin
      n_errors++;
      $display("FAIL lu3_single_inst: stall=%0d expected 1", a_stall_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    EX_branch_taken = 1'b1;
    ID_stale        = 1'b1;
    #1;
    n_checks++;
    if ({a_IF_ID_flush, a_ID_EX_flush, a_pc_write, a_IF_ID_write} !== 4'b1111) begin
      n_errors++;
      $display("FAIL branch_flush: ifflush/exflush/pc/ifw=%b expected 1111",
               {a_IF_ID_flush, a_ID_EX_flush, a_pc_write, a_IF_ID_write});
    end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (a_flush_count !== 16'd1 || a_stall_count !== 16'd0 || a_IF_ID_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL branch_counts: flush=%0d stall=%0d ifflush=%b expected 1 0 0",
               a_flush_count, a_stall_count, a_IF_ID_flush);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ID_stale = 1'b1;
    step();
    ID_stale        = 1'b0;
    EX_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({b_pc_write, b_IF_ID_flush, b_ID_EX_flush} !== 3'b111) begin
      n_errors++;
      $display("FAIL abort_branch: pc/ifflush/exflush=%b expected 111",
               {b_pc_write, b_IF_ID_flush, b_ID_EX_flush});
    end
    step();
    EX_branch_taken = 1'b0;
    #1;
    n_checks++;
    if (b_pc_write !== 1'b1 || b_stall_count !== 4'd1 || b_flush_count !== 4'd1) begin
      n_errors++;
      $display("FAIL abort_after: pc=%b stall=%0d flush=%0d expected 1 1 1",
               b_pc_write, b_stall_count, b_flush_count);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MEM_dmem_req   = 1'b1;
    MEM_dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write} !== 4'b0000) begin
        n_errors++;
        $display("FAIL memwait_cyc%0d: writes=%b expected 0000",
                 i, {a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write});
      end
      step();
    end
    MEM_dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write} !== 4'b1111) begin
      n_errors++;
      $display("FAIL memwait_ready: writes=%b expected 1111",
               {a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write});
    end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (a_stall_count !== 16'd4 || a_pc_write !== 1'b1 || a_halted !== 1'b0) begin
      n_errors++;
      $display("FAIL memwait_done: stall=%0d pc=%b halted=%b expected 4 1 0",
               a_stall_count, a_pc_write, a_halted);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    MEM_dmem_req   = 1'b1;
    MEM_dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (a_halted !== 1'b0 || a_pc_write !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_wait%0d: halted=%b pc=%b expected 0 0", i, a_halted, a_pc_write);
      end
      step();
    end
    n_checks++;
    if (a_halted !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_halt: halted=%b expected 1", a_halted);
    end
    MEM_dmem_ready = 1'b1;
    ID_stale       = 1'b1;
    #1;
    n_checks++;
    if ({a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write, a_IF_ID_flush, a_ID_EX_flush}
        !== 6'b000000) begin
      n_errors++;
      $display("FAIL halt_outputs: got %b expected 000000",
               {a_pc_write, a_IF_ID_write, a_ID_EX_write, a_EX_MEM_write, a_IF_ID_flush, a_ID_EX_flush});
    end
    step();
    n_checks++;
    if (a_halted !== 1'b1 || a_stall_count !== 16'd9) begin
      n_errors++;
      $display("FAIL halt_sticky: halted=%b stall=%0d expected 1 9", a_halted, a_stall_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_halted !== 1'b0 || a_pc_write !== 1'b1 || a_stall_count !== 16'd0) begin
      n_errors++;
      $display("FAIL halt_reset: halted=%b pc=%b stall=%0d expected 0 1 0",
               a_halted, a_pc_write, a_stall_count);
    end
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    MEM_dmem_req   = 1'b1;
    MEM_dmem_ready = 1'b0;
    repeat (20) step();
    n_checks++;
    if (b_stall_count !== 4'd15) begin
      n_errors++;
      $display("FAIL sat_4bit: stall=%0d expected 15", b_stall_count);
    end
    n_checks++;
    if (a_stall_count !== 16'd20) begin
      n_errors++;
      $display("FAIL count_in_halt: stall=%0d expected 20", a_stall_count);
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use_single();
    test_load_use_multi();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
